// File: rtl/mem_pkg.sv
// Shared definitions for the data memory responder.
// Holds the FSM state and op encodings plus default geometry/latency values.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

  typedef enum logic [1:0] {
    OP_RD  = 2'd0,
    OP_WR  = 2'd1,
    OP_BAD = 2'd2
  } mem_op_e;

  localparam int unsigned MEM_DATA_W    = 8;
  localparam int unsigned MEM_ADDR_W    = 8;
  localparam int unsigned MEM_DEPTH     = 256;
  localparam int unsigned MEM_READ_LAT  = 2;
  localparam int unsigned MEM_WRITE_LAT = 1;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the control FSM (master) and the data
// memory responder (slave).
//   MemRead/MemWrite : level request strobes
//   Addr/WriteData   : sampled at acceptance
//   ReadData         : last completed read result
//   MemBusy          : transaction in flight
//   MemReady         : one-cycle completion pulse
//   MemError         : one-cycle failure flag, coincident with MemReady
interface data_mem_responder_if
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = MEM_DATA_W,
  parameter int unsigned ADDR_W = MEM_ADDR_W
) ();

  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] WriteData;
  logic [DATA_W-1:0] ReadData;
  logic              MemBusy;
  logic              MemReady;
  logic              MemError;

  modport master (
    output MemRead, MemWrite, Addr, WriteData,
    input  ReadData, MemBusy, MemReady, MemError
  );

  modport slave (
    input  MemRead, MemWrite, Addr, WriteData,
    output ReadData, MemBusy, MemReady, MemError
  );

endinterface

// File: rtl/mem_array.sv
// Single-port synchronous RAM, DEPTH x DATA_W, with registered read data.
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset (read register only)
//   i_we    : write enable
//   i_re    : read enable; o_rdata holds its value when low
//   i_addr  : word address
//   i_wdata : write data
//   o_rdata : registered read data
module mem_array #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned AW     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)       r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: accepts a MemRead/MemWrite request, waits a
// programmable latency, performs one access on the internal array and
// signals completion with a one-cycle MemReady (plus MemError on failure).
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : slave side of data_mem_responder_if
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W    = MEM_DATA_W,
  parameter int unsigned ADDR_W    = MEM_ADDR_W,
  parameter int unsigned DEPTH     = MEM_DEPTH,
  parameter int unsigned READ_LAT  = MEM_READ_LAT,
  parameter int unsigned WRITE_LAT = MEM_WRITE_LAT
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);

  localparam int unsigned MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT) + 1;
  localparam int unsigned RAM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  mem_state_e        r_state, w_next;
  mem_op_e           r_op;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_busy, r_ready, r_err;

  logic              w_req, w_commit, w_in_range, w_we, w_re;
  logic [DATA_W-1:0] w_rdata;

  assign w_req      = bus.MemRead | bus.MemWrite;
  assign w_commit   = (r_state == MEM_WAIT) && (r_cnt == '0);
  assign w_in_range = (32'(r_addr) < DEPTH);
  // Gating with rst discards an access whose commit edge coincides with reset.
  assign w_we = w_commit && (r_op == OP_WR) && w_in_range && !rst;
  assign w_re = w_commit && (r_op == OP_RD) && w_in_range && !rst;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      MEM_IDLE: if (w_req) w_next = MEM_WAIT;
      MEM_WAIT: if (r_cnt == '0) w_next = MEM_DONE;
      MEM_DONE: w_next = MEM_IDLE;
      default:  w_next = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= MEM_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_op    <= OP_RD;
      r_addr  <= '0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      // Status flags are registered copies of the next state.
      r_busy  <= (w_next == MEM_WAIT);
      r_ready <= (w_next == MEM_DONE);
      r_err   <= w_commit && ((r_op == OP_BAD) || !w_in_range);
      if ((r_state == MEM_IDLE) && w_req) begin
        r_addr  <= bus.Addr;
        r_wdata <= bus.WriteData;
        if (bus.MemRead && bus.MemWrite) begin
          r_op  <= OP_BAD;
          r_cnt <= CNT_W'(READ_LAT - 1);
        end else if (bus.MemRead) begin
          r_op  <= OP_RD;
          r_cnt <= CNT_W'(READ_LAT - 1);
        end else begin
          r_op  <= OP_WR;
          r_cnt <= CNT_W'(WRITE_LAT - 1);
        end
      end else if ((r_state == MEM_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (RAM_AW)
  ) u_mem_array (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_addr  (r_addr[RAM_AW-1:0]),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );

  assign bus.ReadData = w_rdata;
  assign bus.MemBusy  = r_busy;
  assign bus.MemReady = r_ready;
  assign bus.MemError = r_err;

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the control FSM's `MemRead`/`MemWrite` strobes. It latches an address (and write data), waits a programmable number of cycles, then performs a single-port access on an internal 8-bit data array. It reports completion with a one-cycle `MemReady` pulse. It sits between the control FSM/datapath and the data RAM and replaces the zero-latency combinational RAM.

## Interface
- `DATA_W`, 8, data word width
- `ADDR_W`, 8, address width
- `DEPTH`, 256, number of words; must be ≤ 2^ADDR_W
- `READ_LAT`, 2, cycles from acceptance to read completion; must be ≥ 1
- `WRITE_LAT`, 1, cycles from acceptance to write commit; must be ≥ 1

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `MemRead`  in  1  read request strobe (level)
- `MemWrite`  in  1  write request strobe (level)
- `Addr`  in  ADDR_W  word address, sampled at acceptance
- `WriteData`  in  DATA_W  store data, sampled at acceptance
- `ReadData`  out  DATA_W  last read result; held until the next completed read
- `MemBusy`  out  1  transaction in flight (WAIT state)
- `MemReady`  out  1  one-cycle completion pulse
- `MemError`  out  1  one-cycle pulse, coincident with `MemReady`, marking a failed transaction

## Operation
- States: IDLE, WAIT, DONE. Reset and default state is IDLE.
- **IDLE:** if `MemRead | MemWrite` is high at a clock edge:
  - latch `Addr`, `WriteData` and the op;
  - load the counter with LAT−1 (READ_LAT or WRITE_LAT per op);
  - go to WAIT.
- **WAIT:** each edge, if count = 0, perform the access and go to DONE; otherwise decrement.
  - Read: `ReadData` ← array[addr].
  - Write: array[addr] ← data.
- **DONE:** `MemReady` = 1 for this cycle, then go to IDLE. Strobes are ignored in WAIT and DONE.
- **Both strobes high at acceptance:**
  - the transaction is accepted with READ_LAT;
  - no array access occurs and `ReadData` is unchanged;
  - `MemError` = 1 in DONE.
- **Latched address ≥ DEPTH:**
  - no access occurs; no wrap-around or aliasing;
  - a read leaves `ReadData` unchanged;
  - `MemError` = 1 in DONE.
- **Held strobes:** if a strobe is still high in the IDLE cycle after DONE, a new transaction is accepted. The requester must drop the strobe on `MemReady` to avoid a repeat.
- Counter width is clog2(max(READ_LAT, WRITE_LAT)) + 1. Address comparison is unsigned.

## Timing
- Reset values:
  - state IDLE, counter 0;
  - `ReadData` = 0, `MemBusy` = 0, `MemReady` = 0, `MemError` = 0;
  - array contents are not reset.
- Reset mid-operation (WAIT or DONE): return to IDLE. A pending write that has not reached its commit edge is discarded. A write already committed stays.
- Acceptance edge E0: `MemBusy` is high from after E0 until after E_LAT.
- At edge E_LAT the access is performed. `MemReady`, `MemError` and new `ReadData` are visible in the cycle after E_LAT.
- Throughput: one transaction per LAT+2 cycles. Defaults: read 4, write 3.
- `MemBusy` and `MemReady` are never high together.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `mem_pkg`:
  - state encodings `MEM_IDLE`/`MEM_WAIT`/`MEM_DONE` (2-bit);
  - op encodings `OP_RD`/`OP_WR`/`OP_BAD`;
  - default DATA_W, ADDR_W, DEPTH, READ_LAT and WRITE_LAT constants.
- Sub-module `mem_array`:
  - single-port synchronous DEPTH×DATA_W RAM;
  - ports: `clk`, write enable, address, write data, registered read data;
  - the responder drives it only at the commit edge.
- The responder holds the FSM, the latency counter, the request latches and the error logic.

## Test plan
- Reset with random strobes held → all outputs 0 and state IDLE for every cycle `rst` = 1; `MemBusy` = 0 on the first cycle after release with no request.
- Write: `MemWrite` = 1, `Addr` = 0x10, `WriteData` = 0xA5, strobe dropped on ready → `MemReady` in the cycle after edge E1. Then read 0x10 → `MemBusy` for 2 cycles, `MemReady` after E2 with `ReadData` = 0xA5, `MemError` = 0.
- `MemRead` = `MemWrite` = 1 at `Addr` 0x20 (holding 0x3C) → `MemReady` = `MemError` = 1 after E2. A following read of 0x20 returns 0x3C and `ReadData` was unchanged in between.
- DEPTH = 128, write 0x80 with 0xFF → `MemError` pulse. A read of 0x00 then returns its prior value (no alias).
- Write 0x05 ← 0x77 with WRITE_LAT = 3, `rst` pulsed in the WAIT cycle after E1 → no `MemReady`, IDLE after reset; a later read of 0x05 returns the old value.
- `MemRead` held high for 10 cycles at `Addr` 0x01 → `MemReady` at cycles 3 and 7 relative to E0 (period 4). `MemBusy` is never high with `MemReady`.
